// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register sitting behind the integer ALU.
// Captures the ALU result and control bits, turns a trapping arithmetic
// overflow into an Ov exception request to CP0 and holds that request in a
// two-state FSM (RUN / EXC_PEND) until CP0 acknowledges it.
// Optional build macro: ADDR_ALIGN_CHK_EN adds load/store alignment checking
// (AdEL/AdES) and the exc_badvaddr output.
module ex_mem_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter logic [4:0]  EXC_OV = 5'h0C
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_pc,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic              ex_overflow,
  input  logic              ex_ovf_trap,
  input  logic              ex_in_ds,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic              ex_reg_we,
  input  logic              ex_mem_re,
  input  logic              ex_mem_we,
  input  logic [1:0]        ex_mem_size,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic              stall,
  input  logic              flush,
  input  logic              exc_ack,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_pc,
  output logic [DATA_W-1:0] mem_alu_out,
  output logic [REG_AW-1:0] mem_rd_addr,
  output logic              mem_reg_we,
  output logic              mem_mem_re,
  output logic              mem_mem_we,
  output logic [1:0]        mem_mem_size,
  output logic [DATA_W-1:0] mem_store_data,
  output logic              exc_req,
  output logic [4:0]        exc_code,
  output logic [DATA_W-1:0] exc_epc,
  output logic              exc_bd,
`ifdef ADDR_ALIGN_CHK_EN
  output logic [DATA_W-1:0] exc_badvaddr,
`endif
  output logic              ex_ready
);

  localparam logic [4:0] ExcAdel = 5'h04;
  localparam logic [4:0] ExcAdes = 5'h05;

  typedef enum logic {StRun, StExcPend} state_e;

  state_e state_q;

  logic              trap;
  logic              exc_take;
  logic [4:0]        code_next;
  logic [DATA_W-1:0] epc_next;
`ifdef ADDR_ALIGN_CHK_EN
  logic              misalign;
  logic              adr_err;
`endif

  // EX is free to advance whenever MEM is not busy.
  assign ex_ready = !stall;

  // Exception detection for the instruction currently in EX.
  always_comb begin
    trap     = ex_valid & ex_overflow & ex_ovf_trap;
    // Delay-slot faults restart at the branch, one word back.
    epc_next = ex_in_ds ? (ex_pc - DATA_W'(4)) : ex_pc;
`ifdef ADDR_ALIGN_CHK_EN
    misalign = 1'b0;
    if (ex_valid && (ex_mem_re || ex_mem_we)) begin
      if (ex_mem_size == 2'b01) misalign = ex_alu_out[0];
      if (ex_mem_size == 2'b10) misalign = (ex_alu_out[1:0] != 2'b00);
    end
    // Overflow wins over address error.
    adr_err   = !trap && misalign;
    exc_take  = trap || adr_err;
    code_next = trap ? EXC_OV : (ex_mem_re ? ExcAdel : ExcAdes);
`else
    exc_take  = trap;
    code_next = EXC_OV;
`endif
  end

  // Pipeline register, exception registers and FSM; priority rst > flush > stall > capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StRun;
      mem_valid      <= 1'b0;
      mem_pc         <= '0;
      mem_alu_out    <= '0;
      mem_rd_addr    <= '0;
      mem_reg_we     <= 1'b0;
      mem_mem_re     <= 1'b0;
      mem_mem_we     <= 1'b0;
      mem_mem_size   <= 2'b00;
      mem_store_data <= '0;
      exc_req        <= 1'b0;
      exc_code       <= 5'h00;
      exc_epc        <= '0;
      exc_bd         <= 1'b0;
`ifdef ADDR_ALIGN_CHK_EN
      exc_badvaddr   <= '0;
`endif
    end else begin
      // The acknowledge is honoured even during stall or flush.
      if (state_q == StExcPend && exc_ack) begin
        exc_req <= 1'b0;
        state_q <= StRun;
      end

      if (flush) begin
        mem_valid  <= 1'b0;
        mem_reg_we <= 1'b0;
        mem_mem_re <= 1'b0;
        mem_mem_we <= 1'b0;
      end else if (!stall) begin
        if (state_q == StExcPend) begin
          // Everything behind the faulting instruction becomes a bubble.
          mem_valid  <= 1'b0;
          mem_reg_we <= 1'b0;
          mem_mem_re <= 1'b0;
          mem_mem_we <= 1'b0;
        end else begin
          mem_valid      <= ex_valid;
          mem_pc         <= ex_pc;
          mem_alu_out    <= ex_alu_out;
          mem_rd_addr    <= ex_rd_addr;
          mem_mem_size   <= ex_mem_size;
          mem_store_data <= ex_store_data;
          if (exc_take) begin
            // Faulting instruction stays visible but has no side effects.
            mem_reg_we <= 1'b0;
            mem_mem_re <= 1'b0;
            mem_mem_we <= 1'b0;
            exc_req    <= 1'b1;
            exc_code   <= code_next;
            exc_epc    <= epc_next;
            exc_bd     <= ex_in_ds;
            state_q    <= StExcPend;
`ifdef ADDR_ALIGN_CHK_EN
            if (adr_err) exc_badvaddr <= ex_alu_out;
`endif
          end else begin
            mem_reg_we <= ex_reg_we;
            mem_mem_re <= ex_mem_re;
            mem_mem_we <= ex_mem_we;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed self-checking bench for ex_mem_reg.
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_alu_out;
  logic        ex_overflow;
  logic        ex_ovf_trap;
  logic        ex_in_ds;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_we;
  logic        ex_mem_re;
  logic        ex_mem_we;
  logic [1:0]  ex_mem_size;
  logic [31:0] ex_store_data;
  logic        stall;
  logic        flush;
  logic        exc_ack;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic [31:0] mem_alu_out;
  logic [4:0]  mem_rd_addr;
  logic        mem_reg_we;
  logic        mem_mem_re;
  logic        mem_mem_we;
  logic [1:0]  mem_mem_size;
  logic [31:0] mem_store_data;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc;
  logic        exc_bd;
`ifdef ADDR_ALIGN_CHK_EN
  logic [31:0] exc_badvaddr;
`endif
  logic        ex_ready;

  int n_checks = 0;
  int n_fail   = 0;

  ex_mem_reg dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_alu_out     (ex_alu_out),
    .ex_overflow    (ex_overflow),
    .ex_ovf_trap    (ex_ovf_trap),
    .ex_in_ds       (ex_in_ds),
    .ex_rd_addr     (ex_rd_addr),
    .ex_reg_we      (ex_reg_we),
    .ex_mem_re      (ex_mem_re),
    .ex_mem_we      (ex_mem_we),
    .ex_mem_size    (ex_mem_size),
    .ex_store_data  (ex_store_data),
    .stall          (stall),
    .flush          (flush),
    .exc_ack        (exc_ack),
    .mem_valid      (mem_valid),
    .mem_pc         (mem_pc),
    .mem_alu_out    (mem_alu_out),
    .mem_rd_addr    (mem_rd_addr),
    .mem_reg_we     (mem_reg_we),
    .mem_mem_re     (mem_mem_re),
    .mem_mem_we     (mem_mem_we),
    .mem_mem_size   (mem_mem_size),
    .mem_store_data (mem_store_data),
    .exc_req        (exc_req),
    .exc_code       (exc_code),
    .exc_epc        (exc_epc),
    .exc_bd         (exc_bd),
`ifdef ADDR_ALIGN_CHK_EN
    .exc_badvaddr   (exc_badvaddr),
`endif
    .ex_ready       (ex_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plain ALU instruction (no memory access, no trap).
  task automatic set_alu(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] rd);
    ex_valid      = 1'b1;
    ex_pc         = pc;
    ex_alu_out    = res;
    ex_overflow   = 1'b0;
    ex_ovf_trap   = 1'b0;
    ex_in_ds      = 1'b0;
    ex_rd_addr    = rd;
    ex_reg_we     = 1'b1;
    ex_mem_re     = 1'b0;
    ex_mem_we     = 1'b0;
    ex_mem_size   = 2'b10;
    ex_store_data = 32'h0;
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    exc_ack = 1'b0;
    set_alu(32'h0, 32'h0, 5'd0);
    ex_valid = 1'b0;
    #2;
    chk("reset_mem_valid", 32'(mem_valid), 32'd0);
    chk("reset_exc_req", 32'(exc_req), 32'd0);
    chk("reset_ex_ready", 32'(ex_ready), 32'd1);
    tick();
    rst = 1'b0;

    // Normal capture
    set_alu(32'h0000_0100, 32'h0000_1234, 5'd8);
    tick();
    chk("cap_valid", 32'(mem_valid), 32'd1);
    chk("cap_alu", mem_alu_out, 32'h0000_1234);
    chk("cap_rd", 32'(mem_rd_addr), 32'd8);
    chk("cap_reg_we", 32'(mem_reg_we), 32'd1);
    chk("cap_exc_req", 32'(exc_req), 32'd0);

    // addu-class overflow is ignored
    set_alu(32'h0000_0104, 32'h8000_0000, 5'd9);
    ex_overflow = 1'b1;
    tick();
    chk("addu_reg_we", 32'(mem_reg_we), 32'd1);
    chk("addu_exc_req", 32'(exc_req), 32'd0);

    // Overflow trap, not in delay slot
    set_alu(32'h0040_0010, 32'h0000_DEAD, 5'd10);
    ex_overflow = 1'b1;
    ex_ovf_trap = 1'b1;
    tick();
    chk("ov_exc_req", 32'(exc_req), 32'd1);
    chk("ov_exc_code", 32'(exc_code), 32'h0C);
    chk("ov_exc_epc", exc_epc, 32'h0040_0010);
    chk("ov_exc_bd", 32'(exc_bd), 32'd0);
    chk("ov_reg_we", 32'(mem_reg_we), 32'd0);
    chk("ov_valid", 32'(mem_valid), 32'd1);
    chk("ov_alu", mem_alu_out, 32'h0000_DEAD);

    // Bubbles while pending
    set_alu(32'h0040_0014, 32'h0000_5555, 5'd11);
    tick();
    chk("pend1_valid", 32'(mem_valid), 32'd0);
    chk("pend1_reg_we", 32'(mem_reg_we), 32'd0);
    chk("pend1_exc_req", 32'(exc_req), 32'd1);
    tick();
    chk("pend2_valid", 32'(mem_valid), 32'd0);
    chk("pend2_exc_req", 32'(exc_req), 32'd1);

    // Acknowledge: request drops, transition edge is a bubble
    exc_ack = 1'b1;
    tick();
    exc_ack = 1'b0;
    chk("ack_exc_req", 32'(exc_req), 32'd0);
    chk("ack_valid", 32'(mem_valid), 32'd0);
    chk("ack_epc_hold", exc_epc, 32'h0040_0010);
    tick();
    chk("post_ack_valid", 32'(mem_valid), 32'd1);
    chk("post_ack_reg_we", 32'(mem_reg_we), 32'd1);

    // Delay-slot trap
    set_alu(32'h0040_0010, 32'h0000_0001, 5'd12);
    ex_overflow = 1'b1;
    ex_ovf_trap = 1'b1;
    ex_in_ds = 1'b1;
    tick();
    chk("ds_exc_epc", exc_epc, 32'h0040_000C);
    chk("ds_exc_bd", 32'(exc_bd), 32'd1);
    chk("ds_exc_req", 32'(exc_req), 32'd1);

    // Ack taken while stalled
    set_alu(32'h0040_0018, 32'h0000_0002, 5'd13);
    stall = 1'b1;
    exc_ack = 1'b1;
    tick();
    exc_ack = 1'b0;
    stall = 1'b0;
    chk("ack_stall_exc_req", 32'(exc_req), 32'd0);

    // Reset asynchronously while pending
    set_alu(32'h0040_0020, 32'h0000_00AA, 5'd14);
    ex_overflow = 1'b1;
    ex_ovf_trap = 1'b1;
    tick();
    chk("rst_pre_exc_req", 32'(exc_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_exc_req", 32'(exc_req), 32'd0);
    chk("rst_async_valid", 32'(mem_valid), 32'd0);
    chk("rst_async_epc", exc_epc, 32'h0);
    chk("rst_async_code", 32'(exc_code), 32'h0);
    chk("rst_async_alu", mem_alu_out, 32'h0);
    rst = 1'b0;
    set_alu(32'h0000_0200, 32'h0000_AAAA, 5'd15);
    tick();
    chk("rst_next_valid", 32'(mem_valid), 32'd1);
    chk("rst_next_alu", mem_alu_out, 32'h0000_AAAA);
    chk("rst_next_exc_req", 32'(exc_req), 32'd0);

    // Stall holds mem_* for three cycles with changing inputs
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_alu(32'h0000_0300 + 32'(i), 32'h0000_B000 + 32'(i), 5'(20 + i));
      ex_reg_we = 1'b0;
      if (i == 1) begin
        ex_overflow = 1'b1;
        ex_ovf_trap = 1'b1;
      end
      #1;
      chk("stall_ex_ready", 32'(ex_ready), 32'd0);
      tick();
      chk("stall_alu_hold", mem_alu_out, 32'h0000_AAAA);
      chk("stall_reg_we_hold", 32'(mem_reg_we), 32'd1);
      chk("stall_no_exc", 32'(exc_req), 32'd0);
    end

    // Stall and flush together: flush wins
    flush = 1'b1;
    tick();
    chk("stflush_valid", 32'(mem_valid), 32'd0);
    chk("stflush_reg_we", 32'(mem_reg_we), 32'd0);
    stall = 1'b0;

    // Trap with flush is discarded
    set_alu(32'h0000_0400, 32'h0000_0004, 5'd3);
    ex_overflow = 1'b1;
    ex_ovf_trap = 1'b1;
    tick();
    chk("flush_trap_exc_req", 32'(exc_req), 32'd0);
    chk("flush_trap_valid", 32'(mem_valid), 32'd0);
    flush = 1'b0;

    // Trap under stall is re-evaluated once the stall drops
    stall = 1'b1;
    tick();
    chk("stall_trap_exc_req", 32'(exc_req), 32'd0);
    stall = 1'b0;
    tick();
    chk("unstall_trap_exc_req", 32'(exc_req), 32'd1);
    chk("unstall_trap_epc", exc_epc, 32'h0000_0400);
    exc_ack = 1'b1;
    tick();
    exc_ack = 1'b0;
    chk("unstall_ack_exc_req", 32'(exc_req), 32'd0);

    // Misaligned word load
    set_alu(32'h0000_0500, 32'h1000_0002, 5'd4);
    ex_mem_re = 1'b1;
    ex_mem_size = 2'b10;
    tick();
`ifdef ADDR_ALIGN_CHK_EN
    chk("adel_exc_req", 32'(exc_req), 32'd1);
    chk("adel_exc_code", 32'(exc_code), 32'h04);
    chk("adel_badvaddr", exc_badvaddr, 32'h1000_0002);
    chk("adel_mem_re", 32'(mem_mem_re), 32'd0);
    exc_ack = 1'b1;
    tick();
    exc_ack = 1'b0;
`else
    chk("noalign_exc_req", 32'(exc_req), 32'd0);
    chk("noalign_mem_re", 32'(mem_mem_re), 32'd1);
`endif

    // Byte store at an odd address is always fine
    set_alu(32'h0000_0504, 32'h1000_0003, 5'd0);
    ex_reg_we = 1'b0;
    ex_mem_we = 1'b1;
    ex_mem_size = 2'b00;
    ex_store_data = 32'h0000_00EE;
    tick();
    chk("sb_exc_req", 32'(exc_req), 32'd0);
    chk("sb_mem_we", 32'(mem_mem_we), 32'd1);
    chk("sb_size", 32'(mem_mem_size), 32'd0);
    chk("sb_data", mem_store_data, 32'h0000_00EE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- EX/MEM pipeline register directly downstream of the integer ALU.
- Captures the ALU result, overflow flag and control bits each cycle and presents them to the MEM stage.
- Converts a trap-enabled arithmetic overflow into an Ov exception request towards CP0, and kills the offending instruction's side effects.
- Holds the request in a two-state FSM until CP0 acknowledges it.

Parameters:
- DATA_W, 32, datapath / PC width
- REG_AW, 5, register-file address width
- EXC_OV, 5'h0C, exception code driven for arithmetic overflow

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- ex_valid  in  1  EX slot holds a real instruction
- ex_pc  in  DATA_W  PC of EX instruction
- ex_alu_out  in  DATA_W  ALU result (d_out)
- ex_overflow  in  1  ALU overflow flag (EXP_overflow)
- ex_ovf_trap  in  1  instruction traps on overflow (add/addi/sub; 0 for addu/addiu/subu)
- ex_in_ds  in  1  instruction sits in a branch delay slot
- ex_rd_addr  in  REG_AW  destination register
- ex_reg_we  in  1  register write enable
- ex_mem_re  in  1  load
- ex_mem_we  in  1  store
- ex_mem_size  in  2  00 byte, 01 half, 10 word
- ex_store_data  in  DATA_W  store data
- stall  in  1  MEM stage busy; hold register
- flush  in  1  kill EX→MEM transfer
- exc_ack  in  1  CP0 has taken the exception
- mem_valid  out  1  MEM slot valid
- mem_pc  out  DATA_W
- mem_alu_out  out  DATA_W
- mem_rd_addr  out  REG_AW
- mem_reg_we  out  1
- mem_mem_re  out  1
- mem_mem_we  out  1
- mem_mem_size  out  2
- mem_store_data  out  DATA_W
- exc_req  out  1  exception pending to CP0
- exc_code  out  5  cause code
- exc_epc  out  DATA_W  EPC to load
- exc_bd  out  1  Cause.BD value
- ex_ready  out  1  = !stall; EX may advance

Behaviour:
- Clock and reset are decided: one clock, clk; rst asynchronous, active-high.
- On rst, all outputs except ex_ready clear to 0; the FSM goes to RUN.
- ex_ready is combinational !stall.
- Latency is 1 cycle: inputs sampled at a clk edge appear on mem_* after that edge.
- Priority per edge is rst > flush > stall > capture.
  - flush: mem_valid←0, mem_reg_we/mem_mem_re/mem_mem_we←0. Other data fields are don't-care. FSM state is unchanged.
  - stall (no flush): every mem_* register holds its value.
  - capture in RUN: all mem_* fields load from ex_*. mem_valid←ex_valid.
- Trap condition T = ex_valid & ex_overflow & ex_ovf_trap.
  - With T, the capture still loads mem_valid=1, mem_pc and mem_alu_out.
  - mem_reg_we, mem_mem_re and mem_mem_we are forced to 0.
  - exc_req←1, exc_code←EXC_OV, exc_bd←ex_in_ds.
  - exc_epc←ex_in_ds ? ex_pc−4 : ex_pc (modulo 2^DATA_W).
  - FSM goes to EXC_PEND.
- ex_overflow is ignored when ex_ovf_trap=0 (addu-class); the result is written normally.
- FSM:
  - RUN: normal capture. T on a non-stalled, non-flushed edge → EXC_PEND.
  - EXC_PEND: exc_req/exc_code/exc_epc/exc_bd hold. Each non-stalled edge loads a bubble (mem_valid=0, all enables 0) regardless of ex_*.
  - EXC_PEND → RUN on exc_ack. On that edge exc_req←0 and the transition also loads a bubble.
- exc_ack is sampled in EXC_PEND even while stall=1 or flush=1.
- exc_ack in RUN is ignored.
- T coincident with stall is not captured. The overflow is re-evaluated when stall drops.
- T coincident with flush is discarded; no exception is raised.

Optional Feature:
- Macro: ADDR_ALIGN_CHK_EN.
- When defined, misalignment is checked on capture in RUN when ex_valid & (ex_mem_re|ex_mem_we):
  - half with ex_alu_out[0]≠0 is misaligned.
  - word with ex_alu_out[1:0]≠0 is misaligned.
- A misaligned access raises exc_code 5'h04 for a load (AdEL) or 5'h05 for a store (AdES).
- It uses the same EPC/BD rules, forces the enables to 0 and goes to EXC_PEND.
- An added output exc_badvaddr [DATA_W-1:0] latches ex_alu_out and resets to 0.
- Overflow has priority over address error.
- When the macro is undefined, there is no check, no exc_badvaddr port, and ex_mem_size passes through only.

Test Plan:
- Reset mid-operation:
  - Stimulus: assert rst asynchronously between edges while in EXC_PEND.
  - Required: all outputs 0 immediately, FSM RUN, next capture normal.
- Normal capture:
  - Stimulus: ex_valid=1, ex_alu_out=32'h0000_1234, ex_rd_addr=8, ex_reg_we=1.
  - Required: next cycle mem_valid=1, mem_alu_out=32'h1234, mem_reg_we=1, exc_req=0.
- Overflow trap:
  - Stimulus: ex_pc=32'h0040_0010, ex_overflow=1, ex_ovf_trap=1, ex_in_ds=0.
  - Required: exc_req=1, exc_code=5'h0C, exc_epc=32'h0040_0010, mem_reg_we=0. Bubbles follow until exc_ack; exc_req=0 the cycle after ack.
- Delay-slot trap and addu:
  - Stimulus: same trap with ex_in_ds=1.
  - Required: exc_epc=32'h0040_000C, exc_bd=1.
  - Stimulus: separately, ex_overflow=1 with ex_ovf_trap=0.
  - Required: mem_reg_we=1, no exception.
- Stall/flush priority:
  - Stimulus: stall=1 for 3 cycles with changing ex_*.
  - Required: mem_* constant.
  - Stimulus: stall=1 and flush=1 together.
  - Required: mem_valid=0.
  - Stimulus: T with flush=1.
  - Required: no exc_req.
- ADDR_ALIGN_CHK_EN:
  - Stimulus: word load at 32'h1000_0002.
  - Required: exc_code=5'h04, exc_badvaddr=32'h1000_0002.
  - Stimulus: byte store at 32'h1000_0003.
  - Required: no exception.
